baud_gen: RTL and testbench

BAUD_GEN -- requirements
Module: baud_gen

---
 rtl/baud_gen_if.sv | 22 ++
 rtl/baud_gen.sv | 100 ++++++++++
 tb/tb_baud_gen.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/baud_gen_if.sv
// Bus-side signal bundle for baud_gen: register access from the bus
// interface plus the tick and readback outputs.
interface baud_gen_if;
  logic       IOCS;
  logic       IORW;
  logic [1:0] IOADDR;
  logic [7:0] DATABUS_in;
  logic       Enable;
  logic       TxEnable;
  logic [7:0] DIV_OUT;
  logic       DIV_OE;

  modport master (
    output IOCS, IORW, IOADDR, DATABUS_in,
    input  Enable, TxEnable, DIV_OUT, DIV_OE
  );

  modport slave (
    input  IOCS, IORW, IOADDR, DATABUS_in,
    output Enable, TxEnable, DIV_OUT, DIV_OE
  );
endinterface

// File: rtl/baud_gen.sv
// Programmable baud-rate generator: 16-bit down-counter produces a 16x
// oversample tick (Enable); a 4-bit prescaler derives the bit-rate tick
// (TxEnable). Divisor is written low byte (staged) then high byte (commit).
// Optional divisor readback is compiled in with macro BAUD_READBACK_EN.
module baud_gen #(
  parameter logic [15:0] DEFAULT_DIV = 16'd650
) (
  input  logic     clk,
  input  logic     rst,
  baud_gen_if.slave bus
);

  logic [15:0] div_q;
  logic [15:0] cnt_q;
  logic [7:0]  stage_q;
  logic [3:0]  pre_q;
  logic        enable_q;
  logic        tx_q;

  logic        wr;
  logic        lo_wr;
  logic        hi_wr;
  logic [15:0] new_div;

  // Decode register writes; only the divisor addresses are acted upon.
  always_comb begin
    wr      = bus.IOCS & ~bus.IORW;
    lo_wr   = wr & (bus.IOADDR == 2'b10);
    hi_wr   = wr & (bus.IOADDR == 2'b11);
    new_div = {bus.DATABUS_in, stage_q};
  end

  // Divisor registers, down-counter, prescaler and registered tick outputs.
  // A commit outranks the counter reaching zero, so no tick is emitted on
  // the commit edge and timing restarts from the new divisor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= DEFAULT_DIV;
      stage_q  <= DEFAULT_DIV[7:0];
      cnt_q    <= DEFAULT_DIV;
      pre_q    <= '0;
      enable_q <= 1'b0;
      tx_q     <= 1'b0;
    end else begin
      if (lo_wr) begin
        stage_q <= bus.DATABUS_in;
      end
      if (hi_wr) begin
        div_q    <= new_div;
        cnt_q    <= new_div;
        pre_q    <= '0;
        enable_q <= 1'b0;
        tx_q     <= 1'b0;
      end else if (div_q == 16'h0000) begin
        cnt_q    <= '0;
        pre_q    <= '0;
        enable_q <= 1'b0;
        tx_q     <= 1'b0;
      end else if (cnt_q == 16'h0000) begin
        cnt_q    <= div_q;
        pre_q    <= pre_q + 4'd1;
        enable_q <= 1'b1;
        tx_q     <= (pre_q == 4'd15);
      end else begin
        cnt_q    <= cnt_q - 16'd1;
        enable_q <= 1'b0;
        tx_q     <= 1'b0;
      end
    end
  end

  assign bus.Enable   = enable_q;
  assign bus.TxEnable = tx_q;

`ifdef BAUD_READBACK_EN
  logic       oe_q;
  logic [7:0] out_q;

  // Registered readback of the active divisor, one clk after the read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oe_q  <= 1'b0;
      out_q <= '0;
    end else if (bus.IOCS && bus.IORW && bus.IOADDR[1]) begin
      oe_q  <= 1'b1;
      out_q <= bus.IOADDR[0] ? div_q[15:8] : div_q[7:0];
    end else begin
      oe_q  <= 1'b0;
      out_q <= '0;
    end
  end

  assign bus.DIV_OE  = oe_q;
  assign bus.DIV_OUT = out_q;
`else
  assign bus.DIV_OE  = 1'b0;
  assign bus.DIV_OUT = '0;
`endif

endmodule

// File: tb/tb_baud_gen.sv
// Self-checking bench for baud_gen. The reference model counts clk edges
// since the last reset/commit and predicts ticks arithmetically.
module tb_baud_gen;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  baud_gen_if bus();

  baud_gen #(.DEFAULT_DIV(16'd650)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // reference model state
  int unsigned     m_div;
  int unsigned     m_stage;
  longint unsigned m_k;
  logic            exp_en;
  logic            exp_tx;
  logic            exp_oe;
  logic [7:0]      exp_out;
  longint unsigned cyc = 0;

  task automatic model_reset();
    m_div   = 650;
    m_stage = 650 % 256;
    m_k     = 0;
    exp_en  = 1'b0;
    exp_tx  = 1'b0;
    exp_oe  = 1'b0;
    exp_out = 8'h00;
  endtask

  task automatic drive(input logic cs, input logic rw, input logic [1:0] addr, input logic [7:0] data);
    bus.IOCS       = cs;
    bus.IORW       = rw;
    bus.IOADDR     = addr;
    bus.DATABUS_in = data;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 2'b00, 8'h00);
  endtask

  // Advance one clk edge, update the model from the inputs seen at that
  // edge, and return 1 ns later with expectations ready.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst) begin
      model_reset();
    end else begin
`ifdef BAUD_READBACK_EN
      exp_oe  = bus.IOCS && bus.IORW && (bus.IOADDR == 2'b10 || bus.IOADDR == 2'b11);
      exp_out = !exp_oe ? 8'h00 : (bus.IOADDR == 2'b11) ? 8'(m_div / 256) : 8'(m_div % 256);
`else
      exp_oe  = 1'b0;
      exp_out = 8'h00;
`endif
      if (bus.IOCS && !bus.IORW && bus.IOADDR == 2'b11) begin
        m_div = int'(bus.DATABUS_in) * 256 + m_stage;
        m_k   = 0;
      end else begin
        if (bus.IOCS && !bus.IORW && bus.IOADDR == 2'b10) m_stage = bus.DATABUS_in;
        m_k++;
      end
      exp_en = (m_div != 0) && (m_k != 0) && (m_k % (m_div + 1) == 0);
      exp_tx = (m_div != 0) && (m_k != 0) && (m_k % (16 * (m_div + 1)) == 0);
    end
    #1;
  endtask

  task automatic commit(input logic [15:0] d);
    drive(1'b1, 1'b0, 2'b10, d[7:0]);
    tick();
    drive(1'b1, 1'b0, 2'b11, d[15:8]);
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #3 rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.Enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%b exp=0", bus.Enable); end
    checks++; if (bus.TxEnable !== 1'b0) begin errors++; $display("FAIL reset_txenable got=%b exp=0", bus.TxEnable); end
    checks++; if (bus.DIV_OUT !== 8'h00) begin errors++; $display("FAIL reset_div_out got=%h exp=00", bus.DIV_OUT); end
    checks++; if (bus.DIV_OE !== 1'b0) begin errors++; $display("FAIL reset_div_oe got=%b exp=0", bus.DIV_OE); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_default();
    longint unsigned first_en = 0, first_tx = 0;
    int unsigned n_en = 0;
    for (int i = 1; i <= 10416; i++) begin
      tick();
      if (bus.Enable === 1'b1) begin n_en++; if (first_en == 0) first_en = i; end
      if (bus.TxEnable === 1'b1 && first_tx == 0) first_tx = i;
      checks++;
      if (bus.Enable !== exp_en || bus.TxEnable !== exp_tx) begin
        errors++;
        $display("FAIL default_ticks clk=%0d got en=%b tx=%b exp en=%b tx=%b", i, bus.Enable, bus.TxEnable, exp_en, exp_tx);
      end
    end
    checks++; if (first_en != 651) begin errors++; $display("FAIL default_first_enable got=%0d exp=651", first_en); end
    checks++; if (first_tx != 10416) begin errors++; $display("FAIL default_first_txenable got=%0d exp=10416", first_tx); end
    checks++; if (n_en != 16) begin errors++; $display("FAIL default_enable_count got=%0d exp=16", n_en); end
  endtask

  task automatic test_small_div();
    int unsigned n_en = 0, n_tx = 0;
    // low byte alone must leave the default timing running
    drive(1'b1, 1'b0, 2'b10, 8'h03);
    tick();
    idle();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.Enable !== exp_en) begin errors++; $display("FAIL lowbyte_only got=%b exp=%b", bus.Enable, exp_en); end
    end
    drive(1'b1, 1'b0, 2'b11, 8'h00);
    tick();
    idle();
    for (int i = 1; i <= 128; i++) begin
      tick();
      if (bus.Enable === 1'b1) n_en++;
      if (bus.TxEnable === 1'b1) n_tx++;
      checks++;
      if (bus.Enable !== ((i % 4) == 0) || bus.TxEnable !== ((i % 64) == 0)) begin
        errors++;
        $display("FAIL div3_ticks clk=%0d got en=%b tx=%b exp en=%b tx=%b", i, bus.Enable, bus.TxEnable, (i % 4) == 0, (i % 64) == 0);
      end
    end
    checks++; if (n_en != 32 || n_tx != 2) begin errors++; $display("FAIL div3_counts got en=%0d tx=%0d exp en=32 tx=2", n_en, n_tx); end
  endtask

  task automatic test_zero_div();
    int unsigned n = 0;
    commit(16'h0000);
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bus.Enable !== 1'b0 || bus.TxEnable !== 1'b0) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL zero_div_halt got=%0d active cycles exp=0", n); end
    commit(16'h0001);
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (bus.Enable !== ((i % 2) == 0) || bus.TxEnable !== ((i % 32) == 0)) begin
        errors++;
        $display("FAIL div1_ticks clk=%0d got en=%b tx=%b exp en=%b tx=%b", i, bus.Enable, bus.TxEnable, (i % 2) == 0, (i % 32) == 0);
      end
    end
  endtask

  task automatic test_commit_at_zero();
    int unsigned guard = 0;
    commit(16'h0003);
    drive(1'b1, 1'b0, 2'b10, 8'h05);
    tick();
    idle();
    // next edge is the one at which the counter sits at zero
    while (((m_k + 1) % 4) != 0 && guard < 8) begin tick(); guard++; end
    drive(1'b1, 1'b0, 2'b11, 8'h00);
    tick();
    idle();
    checks++; if (bus.Enable !== 1'b0) begin errors++; $display("FAIL commit_at_zero_no_enable got=%b exp=0", bus.Enable); end
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (bus.Enable !== ((i % 6) == 0)) begin errors++; $display("FAIL commit_at_zero_period clk=%0d got=%b exp=%b", i, bus.Enable, (i % 6) == 0); end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 2'b10, 8'h02);
    tick();
    drive(1'b1, 1'b0, 2'b11, 8'h00);
    tick();
    tick();
    idle();
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if (bus.Enable !== ((i % 3) == 0)) begin errors++; $display("FAIL back_to_back clk=%0d got=%b exp=%b", i, bus.Enable, (i % 3) == 0); end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned guard = 0;
    longint unsigned first_en = 0;
    commit(16'h0003);
    tick();
    while (!exp_en && guard < 8) begin tick(); guard++; end
    checks++; if (bus.Enable !== 1'b1) begin errors++; $display("FAIL pre_reset_enable got=%b exp=1", bus.Enable); end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.Enable !== 1'b0 || bus.TxEnable !== 1'b0) begin errors++; $display("FAIL reset_mid_outputs got en=%b tx=%b exp 0 0", bus.Enable, bus.TxEnable); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 700; i++) begin
      tick();
      if (bus.Enable === 1'b1 && first_en == 0) first_en = i;
    end
    checks++; if (first_en != 651) begin errors++; $display("FAIL reset_mid_first_enable got=%0d exp=651", first_en); end
  endtask

  task automatic test_readback();
    logic [7:0] e_hi, e_lo;
    logic       e_oe;
`ifdef BAUD_READBACK_EN
    e_hi = 8'h12; e_lo = 8'h34; e_oe = 1'b1;
`else
    e_hi = 8'h00; e_lo = 8'h00; e_oe = 1'b0;
`endif
    commit(16'h1234);
    drive(1'b1, 1'b1, 2'b11, 8'h00);
    tick();
    checks++; if (bus.DIV_OUT !== e_hi || bus.DIV_OE !== e_oe) begin errors++; $display("FAIL readback_hi got=%h oe=%b exp=%h oe=%b", bus.DIV_OUT, bus.DIV_OE, e_hi, e_oe); end
    drive(1'b1, 1'b1, 2'b10, 8'h00);
    tick();
    checks++; if (bus.DIV_OUT !== e_lo || bus.DIV_OE !== e_oe) begin errors++; $display("FAIL readback_lo got=%h oe=%b exp=%h oe=%b", bus.DIV_OUT, bus.DIV_OE, e_lo, e_oe); end
    idle();
    tick();
    checks++; if (bus.DIV_OE !== 1'b0) begin errors++; $display("FAIL readback_idle_oe got=%b exp=0", bus.DIV_OE); end
  endtask

  task automatic test_max_div();
    longint unsigned first_en = 0;
    int unsigned n_en = 0;
    commit(16'hFFFF);
    for (int i = 1; i <= 65537; i++) begin
      tick();
      if (bus.Enable === 1'b1) begin n_en++; if (first_en == 0) first_en = i; end
    end
    checks++; if (first_en != 65536 || n_en != 1) begin errors++; $display("FAIL max_div_period got first=%0d count=%0d exp first=65536 count=1", first_en, n_en); end
  endtask

  task automatic test_random();
    logic [1:0] a;
    commit(16'h0004);
    for (int i = 0; i < 3000; i++) begin
      a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0)
        drive(1'b1, 1'($urandom_range(0, 1)), a, (a == 2'b11) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 9)));
      else
        drive(1'($urandom_range(0, 1)), 1'b1, a, 8'($urandom));
      tick();
      checks++;
      if (bus.Enable !== exp_en || bus.TxEnable !== exp_tx || bus.DIV_OE !== exp_oe || bus.DIV_OUT !== exp_out) begin
        errors++;
        $display("FAIL random clk=%0d got en=%b tx=%b oe=%b out=%h exp en=%b tx=%b oe=%b out=%h",
                 cyc, bus.Enable, bus.TxEnable, bus.DIV_OE, bus.DIV_OUT, exp_en, exp_tx, exp_oe, exp_out);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_default();
    test_small_div();
    test_zero_div();
    test_commit_at_zero();
    test_back_to_back();
    test_reset_mid();
    test_readback();
    test_max_div();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
